// File: rtl/display_share_scheduler.sv
// Time-shares the 4-digit display between four requesters.
// Round-robin with dwell, requester 0 preempts, blank gap between owners.
module display_share_scheduler #(
  parameter int DWELL_CYCLES = 25_000_000,
  parameter int GAP_CYCLES   = 1_000_000,
  parameter int BLINK_HALF   = 12_500_000,
  parameter int CNT_W        = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] value_bus,
  input  logic [3:0]  blink,
  output logic [3:0]  disp_value,
  output logic        disp_blank,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] dwell_cnt, dwell_n;
  logic [CNT_W-1:0] gap_cnt, gap_n;
  logic [CNT_W-1:0] blink_cnt, bcnt_n;
  logic             blink_phase, phase_n;
  logic [3:0]       grant_n;
  logic [1:0]       owner_n;
  logic [3:0]       value_n;
  logic             blank_n;

  logic             win_vld;
  logic [1:0]       win;
  logic [1:0]       cand;
  logic [3:0]       owner_hot;
  logic [3:0]       own_val;
  logic [3:0]       win_val;
  logic             leave;
  logic             start;

  // Arbitration: requester 0 wins outright, else search from owner+1
  always_comb begin
    win_vld = 1'b0;
    win     = 2'd0;
    cand    = 2'd0;
    if (req[0]) begin
      win_vld = 1'b1;
      win     = 2'd0;
    end else begin
      for (int k = 4; k >= 1; k--) begin
        cand = owner + 2'(k);
        if (req[cand]) begin
          win_vld = 1'b1;
          win     = cand;
        end
      end
    end
  end

  assign owner_hot = 4'b0001 << owner;
  assign own_val   = value_bus[{owner, 2'b00} +: 4];
  assign win_val   = value_bus[{win, 2'b00} +: 4];
  assign busy      = (state != IDLE);

  // Exit from SHOW: release, preempt by 0, or dwell expiry with contenders
  always_comb begin
    leave = 1'b0;
    if (!req[owner]) begin
      leave = 1'b1;
    end else if (req[0] && owner != 2'd0) begin
      leave = 1'b1;
    end else if (dwell_cnt == DWELL_LAST && |(req & ~owner_hot)) begin
      leave = 1'b1;
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    value_n = disp_value;
    blank_n = disp_blank;
    dwell_n = dwell_cnt;
    gap_n   = gap_cnt;
    bcnt_n  = blink_cnt;
    phase_n = blink_phase;
    start   = 1'b0;
    unique case (state)
      IDLE: begin
        grant_n = '0;
        value_n = '0;
        blank_n = 1'b1;
        start   = win_vld;
      end
      SHOW: begin
        if (leave) begin
          state_n = GAP;
          grant_n = '0;
          value_n = '0;
          blank_n = 1'b1;
          gap_n   = '0;
        end else begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_n = '0;
          end else begin
            dwell_n = dwell_cnt + 1'b1;
          end
          if (blink_cnt == BLINK_LAST) begin
            bcnt_n  = '0;
            phase_n = ~blink_phase;
          end else begin
            bcnt_n  = blink_cnt + 1'b1;
          end
          value_n = own_val;
          blank_n = blink[owner] & phase_n;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (win_vld) begin
            start = 1'b1;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            value_n = '0;
            blank_n = 1'b1;
          end
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        value_n = '0;
        blank_n = 1'b1;
      end
    endcase
    if (start) begin
      state_n = SHOW;
      grant_n = 4'b0001 << win;
      owner_n = win;
      value_n = win_val;
      blank_n = 1'b0;
      dwell_n = '0;
      bcnt_n  = '0;
      phase_n = 1'b0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= 2'd3;
      disp_value  <= '0;
      disp_blank  <= 1'b1;
      dwell_cnt   <= '0;
      gap_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      owner       <= owner_n;
      disp_value  <= value_n;
      disp_blank  <= blank_n;
      dwell_cnt   <= dwell_n;
      gap_cnt     <= gap_n;
      blink_cnt   <= bcnt_n;
      blink_phase <= phase_n;
    end
  end

endmodule
